// File: rtl/fft_frame_streamer.sv
// fft_frame_streamer: collects N complex samples from an input stream into a
// frame buffer and pulses fft_start to launch a parallel FFT core. After a
// fixed latency it captures the core result. It then serialises the bins onto
// an output stream in natural or fftshift order. A frame terminated early with
// s_last is zero-padded to N entries.
//
// Handshake semantics, both streams: a beat transfers on a rising edge where
// valid && ready are both high. A producer holding valid keeps its payload
// stable and does not drop valid until that transfer. s_ready and m_valid are
// registered outputs.
module fft_frame_streamer #(
  parameter int N_POINTS  = 16,
  parameter int DW        = 16,
  parameter int FFT_LAT   = 4,
  parameter int SHIFT_OUT = 0,
  parameter int IW        = $clog2(N_POINTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DW-1:0]     s_real,
  input  logic signed [DW-1:0]     s_imag,
  input  logic                     s_last,
  output logic [N_POINTS*DW-1:0]   fft_real_flat,
  output logic [N_POINTS*DW-1:0]   fft_imag_flat,
  output logic                     fft_start,
  input  logic [N_POINTS*DW-1:0]   res_real_flat,
  input  logic [N_POINTS*DW-1:0]   res_imag_flat,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DW-1:0]     m_real,
  output logic signed [DW-1:0]     m_imag,
  output logic [IW-1:0]            m_index,
  output logic                     m_last,
  output logic [15:0]              frame_cnt,
  output logic                     pad_flag,
  output logic [1:0]               dbg_state
);

  localparam int LW = $clog2(FFT_LAT + 1);
  // Bin presented on beat 0; later beats follow it modulo N through IW-bit wrap.
  localparam logic [IW-1:0] FIRST_BIN = (SHIFT_OUT != 0) ? IW'(N_POINTS / 2) : '0;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                  state_q;
  logic [IW-1:0]           wr_cnt_q;
  logic [LW-1:0]           lat_cnt_q;
  logic [IW-1:0]           beat_q;
  logic                    pad_q;
  logic [DW-1:0]           out_real_q [N_POINTS];
  logic [DW-1:0]           out_imag_q [N_POINTS];
  logic [N_POINTS*DW-1:0]  fft_real_q;
  logic [N_POINTS*DW-1:0]  fft_imag_q;
  logic                    s_ready_q;
  logic                    fft_start_q;
  logic                    m_valid_q;
  logic                    m_last_q;
  logic [IW-1:0]           m_index_q;
  logic [DW-1:0]           m_real_q;
  logic [DW-1:0]           m_imag_q;
  logic [15:0]             frame_cnt_q;
  logic                    pad_flag_q;

  logic                    accept;
  logic                    out_hs;
  logic [IW-1:0]           beat_d;
  logic [IW-1:0]           bin_d;

  assign accept = (state_q == ST_FILL) && s_valid && s_ready_q;
  assign out_hs = m_valid_q && m_ready;
  assign beat_d = beat_q + 1'b1;
  assign bin_d  = beat_d + FIRST_BIN;

  // Frame FSM: fill the input buffer, launch and wait for the core, drain bins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FILL;
      wr_cnt_q    <= '0;
      lat_cnt_q   <= '0;
      beat_q      <= '0;
      pad_q       <= 1'b0;
      fft_real_q  <= '0;
      fft_imag_q  <= '0;
      s_ready_q   <= 1'b0;
      fft_start_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_index_q   <= '0;
      m_real_q    <= '0;
      m_imag_q    <= '0;
      frame_cnt_q <= '0;
      pad_flag_q  <= 1'b0;
      for (int k = 0; k < N_POINTS; k++) begin
        out_real_q[k] <= '0;
        out_imag_q[k] <= '0;
      end
    end else begin
      fft_start_q <= 1'b0;
      case (state_q)
        ST_FILL: begin
          s_ready_q <= 1'b1;
          if (accept) begin
            fft_real_q[int'(wr_cnt_q)*DW +: DW] <= s_real;
            fft_imag_q[int'(wr_cnt_q)*DW +: DW] <= s_imag;
            wr_cnt_q <= wr_cnt_q + 1'b1;
            if (wr_cnt_q == IW'(N_POINTS - 1)) begin
              // Full frame: any s_last on this sample carries no information.
              pad_q       <= 1'b0;
              s_ready_q   <= 1'b0;
              fft_start_q <= 1'b1;
              lat_cnt_q   <= '0;
              state_q     <= ST_RUN;
            end else if (s_last) begin
              // Short frame: zero the unwritten tail so the core sees a padded frame.
              for (int k = 0; k < N_POINTS; k++) begin
                if (k > int'(wr_cnt_q)) begin
                  fft_real_q[k*DW +: DW] <= '0;
                  fft_imag_q[k*DW +: DW] <= '0;
                end
              end
              pad_q       <= 1'b1;
              s_ready_q   <= 1'b0;
              fft_start_q <= 1'b1;
              lat_cnt_q   <= '0;
              state_q     <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (lat_cnt_q == LW'(FFT_LAT)) begin
            for (int k = 0; k < N_POINTS; k++) begin
              out_real_q[k] <= res_real_flat[k*DW +: DW];
              out_imag_q[k] <= res_imag_flat[k*DW +: DW];
            end
            // Beat 0 comes straight from the core result being captured.
            m_real_q   <= res_real_flat[int'(FIRST_BIN)*DW +: DW];
            m_imag_q   <= res_imag_flat[int'(FIRST_BIN)*DW +: DW];
            m_index_q  <= FIRST_BIN;
            m_last_q   <= 1'b0;
            m_valid_q  <= 1'b1;
            beat_q     <= '0;
            pad_flag_q <= pad_q;
            state_q    <= ST_DRAIN;
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (out_hs) begin
            if (beat_q == IW'(N_POINTS - 1)) begin
              m_valid_q   <= 1'b0;
              m_last_q    <= 1'b0;
              s_ready_q   <= 1'b1;
              wr_cnt_q    <= '0;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              state_q     <= ST_FILL;
            end else begin
              beat_q    <= beat_d;
              m_index_q <= bin_d;
              m_real_q  <= out_real_q[bin_d];
              m_imag_q  <= out_imag_q[bin_d];
              m_last_q  <= (beat_d == IW'(N_POINTS - 1));
            end
          end
        end
        default: begin
          state_q <= ST_FILL;
        end
      endcase
    end
  end

  assign s_ready       = s_ready_q;
  assign fft_real_flat = fft_real_q;
  assign fft_imag_flat = fft_imag_q;
  assign fft_start     = fft_start_q;
  assign m_valid       = m_valid_q;
  assign m_last        = m_last_q;
  assign m_index       = m_index_q;
  assign m_real        = m_real_q;
  assign m_imag        = m_imag_q;
  assign frame_cnt     = frame_cnt_q;
  assign pad_flag      = pad_flag_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/fft_frame_streamer.md
# fft_frame_streamer

Parametrised stream-to-frame adapter that sits in front of the parallel radix-2 FFT cores. It collects N complex samples from a valid/ready input stream into a frame buffer, launches the core with a one-cycle start pulse and captures its parallel result after a fixed latency. It then serialises the bins onto a valid/ready output stream in natural or fftshift order, zero-padding frames that are terminated early.

## Interface
- N_POINTS, 16, FFT size; power of two, 4..64
- DW, 16, signed sample width (real and imag each)
- FFT_LAT, 4, cycles from fft_start to valid core result; >= 1
- SHIFT_OUT, 0, 0 = natural bin order, 1 = fftshift order (N/2..N-1, 0..N/2-1)
- IW, $clog2(N_POINTS), bin index width (derived)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample ready
- s_real / s_imag  in  DW  signed input sample
- s_last  in  1  marks final sample of a short frame
- fft_real_flat / fft_imag_flat  out  N_POINTS*DW  frame to core; element k at bits [k*DW +: DW]
- fft_start  out  1  one-cycle core launch pulse
- res_real_flat / res_imag_flat  in  N_POINTS*DW  core result, same packing
- m_valid  out  1  output bin valid
- m_ready  in  1  output bin ready
- m_real / m_imag  out  DW  output bin value
- m_index  out  IW  bin number of the current beat
- m_last  out  1  final beat of frame
- frame_cnt  out  16  completed frames; wraps at 0xFFFF -> 0
- pad_flag  out  1  sticky per frame: current output frame was zero-padded

## Operation
- States: FILL, RUN, DRAIN.
- FILL: s_ready=1. On s_valid&&s_ready, store the sample at wr_cnt and increment wr_cnt.
  - Acceptance at wr_cnt==N-1 -> RUN.
  - Acceptance with s_last at wr_cnt<N-1 -> entries wr_cnt+1..N-1 cleared to 0 on the same edge; pad bit set; -> RUN.
  - s_last at wr_cnt==N-1 is ignored (full frame, no pad).
- RUN: fft_start=1 in the first RUN cycle only. A latency counter runs. res_* are captured into the output buffer exactly FFT_LAT cycles after the fft_start cycle; the block then moves to DRAIN.
- DRAIN: m_valid=1 and one bin per handshake.
  - Beat j presents bin j (SHIFT_OUT=0) or bin (j+N/2) mod N (SHIFT_OUT=1).
  - m_index equals the bin number.
  - m_last=1 on beat N-1.
  - After the handshake of beat N-1: frame_cnt+1, wr_cnt=0, -> FILL.
- fft_*_flat are held stable from fft_start until the next frame's first accepted sample.
- pad_flag is updated at capture and remains valid throughout DRAIN.
- No arithmetic on data; values pass bit-exact.

## Timing
- Reset (rst=0, asynchronous): state=FILL, wr_cnt=0, buffers 0.
  - Outputs reset to 0: s_ready, fft_start, m_valid, m_last, m_index, m_real, m_imag, fft_*_flat, frame_cnt, pad_flag.
  - s_ready rises on the first clk edge after release; it is registered.
- If the last sample is accepted at edge c: fft_start is high in cycle c+1, capture happens at edge c+1+FFT_LAT, and m_valid is high from cycle c+2+FFT_LAT.
- s_ready=0 throughout RUN and DRAIN. It returns to 1 in the cycle after the final output handshake, so there is no input overlap.
- Output stream: m_real/m_imag/m_index/m_last are held stable while m_valid && !m_ready. m_valid never drops before its handshake.
- Reset asserted mid-RUN or mid-DRAIN: the frame is discarded, no further fft_start or m_valid is issued, and frame_cnt is cleared.
- frame_cnt increments on the edge of the m_last handshake.

## Test plan
- Bench core is a loopback: res = fft_* delayed FFT_LAT=4. Defaults otherwise.
- Ramp frame: real k = k*0x0010, imag k = -k, s_valid continuous, m_ready=1.
  - fft_start is a single pulse 1 cycle after the 16th accept.
  - m_valid rises 6 cycles after the 16th accept.
  - Beats carry index 0..15 with real 0x0000..0x00F0; m_last on beat 15; frame_cnt=1; pad_flag=0.
- SHIFT_OUT=1, same ramp: index order is 8..15,0..7 and the first beat's real is 0x0080; m_last is on index 7.
- Short frame: s_last on the 5th sample (values 1..5).
  - fft_real_flat elements 5..15 are 0; pad_flag=1.
  - 16 output beats are produced, beats 5..15 equal to 0.
- Backpressure: m_ready pattern 1,0,1,0, s_valid held high during DRAIN.
  - s_ready stays 0; each bin is delivered exactly once and is stable while stalled.
  - The next frame is accepted only after m_last.
- Reset mid-DRAIN after 3 beats:
  - m_valid, frame_cnt and s_ready drop immediately.
  - s_ready=1 one edge after release.
  - The next full frame outputs correctly with frame_cnt=1.
